muxn_stage: RTL and testbench
=============================

MUXN_STAGE -- requirements
Module: muxn_stage

Interface
REQ-001 Parameter WIDTH, default 32, data width of each input channel and of the output.
REQ-002 Parameter N, default 4, number of input channels; legal range 2..16.
REQ-003 Parameter SELW, default $clog2(N), width of the select field; derived, SHALL NOT be overridden.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_data  input  N*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 sel  input  SELW  binary channel select, sampled with in_valid.
REQ-008 in_valid  input  1  upstream offers in_data/sel this cycle.
REQ-009 in_ready  output  1  stage can accept this cycle.
REQ-010 flush  input  1  discard all held entries (pipeline kill).
REQ-011 out_data  output  WIDTH  selected, registered channel data.
REQ-012 out_valid  output  1  out_data holds a valid entry.
REQ-013 out_ready  input  1  downstream accepts out_data this cycle.
REQ-014 sel_err  output  1  one-cycle pulse: an accepted beat had sel >= N.

Function
REQ-015 An input beat SHALL be accepted when in_valid && in_ready && !flush.
REQ-016 An accepted beat SHALL capture in_data[sel*WIDTH +: WIDTH]; if sel >= N it SHALL capture all zeros.
REQ-017 Latency SHALL be one cycle: a beat accepted in cycle t, with the stage empty, appears on out_data with out_valid=1 in cycle t+1.
REQ-018 Storage SHALL be two entries: a main register driving out_data and a skid register.
REQ-019 in_ready SHALL be registered and equal to !skid_full; in_ready SHALL NOT depend combinationally on out_ready.
REQ-020 If a beat is accepted while the main entry is valid and out_ready=0, the beat SHALL go to the skid register.
REQ-021 When the main entry is consumed (out_valid && out_ready) and skid is full, skid SHALL move to main in the same edge.
REQ-022 Simultaneous accept and consume with skid empty SHALL load the new beat into main; no bubble.
REQ-023 Beat order SHALL be preserved; no beat SHALL be dropped or duplicated except by flush.
REQ-024 While out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-025 flush=1 SHALL invalidate main and skid at the next edge: out_valid=0 and in_ready=1 in the following cycle.
REQ-026 In a flush cycle, any input beat SHALL be dropped, and flush SHALL take priority over accept and consume.
REQ-027 sel_err SHALL be high for exactly the cycle after an accepted beat with sel >= N; it is not asserted for flushed-cycle inputs.
REQ-028 Throughput SHALL be one beat per cycle when out_ready is held high.

Reset
REQ-029 While reset=1 at an edge: out_valid=0, skid empty, in_ready=0 during reset, sel_err=0, out_data=0.
REQ-030 in_ready SHALL become 1 in the first cycle after reset deasserts.
REQ-031 Reset asserted mid-transfer SHALL discard both entries, with no partial beat emitted afterwards.

Structure
REQ-032 A shared package SHALL hold the default WIDTH and N constants and the channel-slice helper function.
REQ-033 The combinational N-way selector SHALL be a separate sub-module, muxn, parametrised by WIDTH and N, with a zero output for out-of-range sel; muxn_stage SHALL instantiate it once.

Verification
REQ-034 Streaming: N=4, out_ready=1, in_data channels {A0,B1,C2,D3}, sel=0,1,2,3 on consecutive cycles -> out_data A0,B1,C2,D3 on cycles t+1..t+4; in_ready stays 1.
REQ-035 Backpressure: out_ready=0 with 3 beats offered -> 2 beats held, in_ready=0 from the cycle after the second accept; out_data is stable. Then out_ready=1 -> beats emitted in order with no loss.
REQ-036 Flush: main and skid both full, flush=1 with in_valid=1 -> next cycle out_valid=0 and in_ready=1; the flushed input never appears.
REQ-037 Bad select: N=3, sel=3 accepted -> out_data=0 and sel_err=1 for one cycle.
REQ-038 Reset: assert reset for 1 cycle while 2 beats are held -> out_valid=0 and sel_err=0; in_ready=1 one cycle after release; no stale beat is emitted.
REQ-039 Random stall/flush soak, WIDTH=8, N=16, 10k cycles -> scoreboard matches every non-flushed beat in order.

Source files
------------

// File: rtl/muxn_stage_pkg.sv
// Shared constants and helpers for the registered N-way select stage.
package muxn_stage_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_N     = 4;

  // Bit offset of channel k inside a packed bus of width-bit channels.
  function automatic int chan_lsb(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/muxn.sv
// Combinational N-way channel selector.
// A select value that names no channel yields zero data and raises sel_bad.
module muxn
  import muxn_stage_pkg::*;
#(
  parameter int  WIDTH = DEFAULT_WIDTH,
  parameter int  N     = DEFAULT_N,
  localparam int SELW  = $clog2(N)
) (
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               sel_bad
);

  // Scan every channel; only an exact select match overrides the zero default.
  always_comb begin
    out_data = '0;
    sel_bad  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (sel == SELW'(k)) begin
        out_data = in_data[chan_lsb(k, WIDTH) +: WIDTH];
        sel_bad  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/muxn_stage.sv
// Registered N-way select stage with a two-entry (main + skid) buffer.
// in_ready is a flop equal to "skid empty", so upstream never sees a
// combinational path from out_ready.
module muxn_stage
  import muxn_stage_pkg::*;
#(
  parameter int  WIDTH = DEFAULT_WIDTH,
  parameter int  N     = DEFAULT_N,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err
);

  logic [WIDTH-1:0] mux_data;
  logic             mux_bad;

  logic [WIDTH-1:0] main_data, main_data_n;
  logic             main_valid, main_valid_n;
  logic [WIDTH-1:0] skid_data, skid_data_n;
  logic             skid_valid, skid_valid_n;
  logic             in_ready_q;
  logic             sel_err_q;

  logic accept;
  logic consume;

  muxn #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_muxn (
    .in_data  (in_data),
    .sel      (sel),
    .out_data (mux_data),
    .sel_bad  (mux_bad)
  );

  assign accept  = in_valid && in_ready_q && !flush;
  assign consume = main_valid && out_ready;

  // Next buffer contents: flush wins, then consume (skid refills main), then accept.
  always_comb begin
    main_valid_n = main_valid;
    main_data_n  = main_data;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else if (consume) begin
      if (skid_valid) begin
        main_data_n  = skid_data;
        skid_valid_n = 1'b0;
      end else if (accept) begin
        main_data_n = mux_data;
      end else begin
        main_valid_n = 1'b0;
      end
    end else if (accept) begin
      if (main_valid) begin
        skid_data_n  = mux_data;
        skid_valid_n = 1'b1;
      end else begin
        main_data_n  = mux_data;
        main_valid_n = 1'b1;
      end
    end
  end

  // State registers; reset clears both entries and holds in_ready low.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready_q <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      main_valid <= main_valid_n;
      main_data  <= main_data_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      in_ready_q <= !skid_valid_n;
      sel_err_q  <= accept && mux_bad;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = main_data;
  assign out_valid = main_valid;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_muxn_stage.sv
// Bench for muxn_stage: a 16-channel and a 3-channel instance share all
// handshake inputs; a FIFO-of-two queue model predicts both every cycle.
module tb_muxn_stage;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d16;
    logic [W-1:0] d3;
  } beat_t;

  logic          clk;
  logic          reset;
  logic [16*W-1:0] in_data;
  logic [3:0]    sel;
  logic          in_valid;
  logic          flush;
  logic          out_ready;

  logic          in_ready16, out_valid16, sel_err16;
  logic [W-1:0]  out_data16;
  logic          in_ready3, out_valid3, sel_err3;
  logic [W-1:0]  out_data3;

  int n_checks = 0;
  int n_fails  = 0;

  beat_t q[$];
  beat_t nb;
  logic  m_ready = 1'b0;
  logic  m_err3  = 1'b0;
  logic  m_armed = 1'b0;
  logic  m_acc;

  muxn_stage #(.WIDTH(W), .N(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready16),
    .flush     (flush),
    .out_data  (out_data16),
    .out_valid (out_valid16),
    .out_ready (out_ready),
    .sel_err   (sel_err16)
  );

  muxn_stage #(.WIDTH(W), .N(3)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data[3*W-1:0]),
    .sel       (sel[1:0]),
    .in_valid  (in_valid),
    .in_ready  (in_ready3),
    .flush     (flush),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready),
    .sel_err   (sel_err3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of handshake inputs and move to just after the next edge.
  task automatic applyStimulus(input logic v, input logic [3:0] s,
                               input logic ordy, input logic fl);
    in_valid  = v;
    sel       = s;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of at most two beats, ready when fewer than two held.
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_ready = 1'b0;
      m_err3  = 1'b0;
      m_armed = 1'b1;
    end else if (flush) begin
      q.delete();
      m_ready = 1'b1;
      m_err3  = 1'b0;
    end else begin
      m_acc = in_valid && m_ready;
      nb.d16 = in_data[int'(sel) * W +: W];
      nb.d3  = (sel[1:0] < 2'd3) ? in_data[int'(sel[1:0]) * W +: W] : 8'h00;
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (m_acc) q.push_back(nb);
      m_ready = (q.size() < 2);
      m_err3  = m_acc && (sel[1:0] == 2'd3);
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    if (m_armed) begin
      checkOutput("in_ready16", 32'(in_ready16), 32'(m_ready));
      checkOutput("in_ready3", 32'(in_ready3), 32'(m_ready));
      checkOutput("out_valid16", 32'(out_valid16), 32'(q.size() > 0));
      checkOutput("out_valid3", 32'(out_valid3), 32'(q.size() > 0));
      checkOutput("sel_err16", 32'(sel_err16), 32'(0));
      checkOutput("sel_err3", 32'(sel_err3), 32'(m_err3));
      if (q.size() > 0) begin
        checkOutput("out_data16", 32'(out_data16), 32'(q[0].d16));
        checkOutput("out_data3", 32'(out_data3), 32'(q[0].d3));
      end
    end
  end

  initial begin
    logic [W-1:0] stream_exp [4];
    stream_exp[0] = 8'hA0;
    stream_exp[1] = 8'hB1;
    stream_exp[2] = 8'hC2;
    stream_exp[3] = 8'hD3;

    reset     = 1'b1;
    in_valid  = 1'b0;
    sel       = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    in_data   = {$urandom, $urandom, $urandom, $urandom};
    in_data[31:0] = 32'hD3C2B1A0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", 32'(in_ready16), 32'(0));
    checkOutput("reset out_data", 32'(out_data16), 32'(0));
    reset = 1'b0;
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("ready after reset", 32'(in_ready16), 32'(1));

    $display("[TB] streaming");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 4'(k), 1'b1, 1'b0);
      checkOutput("stream data", 32'(out_data16), 32'(stream_exp[k]));
      checkOutput("stream valid", 32'(out_valid16), 32'(1));
      checkOutput("stream ready", 32'(in_ready16), 32'(1));
    end
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b0);
    checkOutput("bp first", 32'(out_data16), 32'hA0);
    checkOutput("bp ready1", 32'(in_ready16), 32'(1));
    applyStimulus(1'b1, 4'd1, 1'b0, 1'b0);
    checkOutput("bp ready2", 32'(in_ready16), 32'(0));
    checkOutput("bp stable", 32'(out_data16), 32'hA0);
    applyStimulus(1'b1, 4'd2, 1'b0, 1'b0);
    checkOutput("bp ready3", 32'(in_ready16), 32'(0));
    checkOutput("bp stable2", 32'(out_data16), 32'hA0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("bp second", 32'(out_data16), 32'hB1);
    checkOutput("bp second valid", 32'(out_valid16), 32'(1));
    checkOutput("bp ready back", 32'(in_ready16), 32'(1));
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("bp drained", 32'(out_valid16), 32'(0));

    $display("[TB] flush");
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd1, 1'b0, 1'b0);
    checkOutput("flush full", 32'(in_ready16), 32'(0));
    applyStimulus(1'b1, 4'd3, 1'b1, 1'b1);
    checkOutput("flush valid", 32'(out_valid16), 32'(0));
    checkOutput("flush ready", 32'(in_ready16), 32'(1));
    applyStimulus(1'b1, 4'd3, 1'b1, 1'b1);
    checkOutput("flush drop", 32'(out_valid16), 32'(0));
    checkOutput("flush no err", 32'(sel_err3), 32'(0));
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("flush nothing", 32'(out_valid16), 32'(0));

    $display("[TB] bad select");
    applyStimulus(1'b1, 4'd3, 1'b1, 1'b0);
    checkOutput("bad sel data", 32'(out_data3), 32'(0));
    checkOutput("bad sel valid", 32'(out_valid3), 32'(1));
    checkOutput("bad sel err", 32'(sel_err3), 32'(1));
    checkOutput("good sel data16", 32'(out_data16), 32'hD3);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("bad sel err pulse", 32'(sel_err3), 32'(0));

    $display("[TB] reset mid-transfer");
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd1, 1'b0, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("rst valid", 32'(out_valid16), 32'(0));
    checkOutput("rst err", 32'(sel_err3), 32'(0));
    checkOutput("rst ready", 32'(in_ready16), 32'(0));
    checkOutput("rst data", 32'(out_data16), 32'(0));
    reset = 1'b0;
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("rst release ready", 32'(in_ready16), 32'(1));
    checkOutput("rst no stale", 32'(out_valid16), 32'(0));

    $display("[TB] random soak");
    for (int i = 0; i < 10000; i++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      reset   = ($urandom_range(0, 999) == 0);
      applyStimulus($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
    end
    reset = 1'b0;
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("soak drained", 32'(out_valid16), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
